// File: rtl/alu_result_stage.sv
// alu_result_stage
// EX-side result register between the ALU and the MEM/WB stage. Buffers the
// ALU result, zero flag, AluOp and writeback controls in a two-entry skid
// buffer (main register M drives out_*, skid register S absorbs one extra
// entry). Resolves beq/bne on accept and emits a one-cycle redirect pulse.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready registered)
//   in_out, in_zf, in_aluop   ALU result word, zero flag, operation code
//   in_rd, in_regwrite        destination register and writeback enable
//   in_branch, in_bne         conditional branch flag, bne(1)/beq(0)
//   in_pc4, in_imm            PC+4 and sign-extended word offset
//   out_valid / out_ready     downstream handshake
//   out_result ... out_regwrite  buffered entry fields
//   br_valid, br_target       one-cycle redirect pulse and its target
//   n_results, n_taken        wrapping delivered-result / taken-branch counters
//
// state | meaning
// EMPTY | no entry held; M is stale
// ONE   | M holds the head entry, S unused
// FULL  | M holds the head, S holds the next entry; upstream stalled

module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_out,
    input  logic              in_zf,
    input  logic [3:0]        in_aluop,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_regwrite,
    input  logic              in_branch,
    input  logic              in_bne,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zf,
    output logic [3:0]        out_aluop,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_regwrite,
    output logic              br_valid,
    output logic [DATA_W-1:0] br_target,
    output logic [CNT_W-1:0]  n_results,
    output logic [CNT_W-1:0]  n_taken
);

    localparam int ENT_W = DATA_W + 1 + 4 + REG_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t state, state_nxt;

    logic [ENT_W-1:0]  m_q, s_q, in_ent;
    logic              accept, deliver, taken;
    logic              load_m_in, load_s_in, load_m_s;
    logic [DATA_W-1:0] target;

    assign accept = in_valid & in_ready;
    assign deliver = out_valid & out_ready;
    assign in_ent = {in_out, in_zf, in_aluop, in_rd, in_regwrite};
    assign taken = in_branch & (in_bne ? ~in_zf : in_zf);
    // Offset is in words; the shift drops the top bits so wrap-around is silent.
    assign target = in_pc4 + (in_imm << 2);

    always_comb begin
        state_nxt = state;
        load_m_in = 1'b0;
        load_s_in = 1'b0;
        load_m_s  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    state_nxt = FULL;
                    load_s_in = 1'b1;
                end else if (deliver && !accept) begin
                    state_nxt = EMPTY;
                end else if (accept && deliver) begin
                    load_m_in = 1'b1;
                end
            end
            FULL: begin
                if (deliver) begin
                    state_nxt = ONE;
                    load_m_s  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
        end else begin
            state <= state_nxt;
            // Handshake flags are registered copies of the next occupancy so
            // no input reaches an output combinationally.
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            if (load_m_in) begin
                m_q <= in_ent;
            end else if (load_m_s) begin
                m_q <= s_q;
            end
            if (load_s_in) begin
                s_q <= in_ent;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_valid  <= 1'b0;
            br_target <= '0;
            n_results <= '0;
            n_taken   <= '0;
        end else begin
            br_valid <= accept & taken;
            if (accept && taken) begin
                br_target <= target;
                n_taken   <= n_taken + CNT_W'(1);
            end
            if (deliver) begin
                n_results <= n_results + CNT_W'(1);
            end
        end
    end

    assign {out_result, out_zf, out_aluop, out_rd, out_regwrite} = m_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_out;
    logic        in_zf;
    logic [3:0]  in_aluop;
    logic [4:0]  in_rd;
    logic        in_regwrite, in_branch, in_bne;
    logic [31:0] in_pc4, in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_zf;
    logic [3:0]  out_aluop;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic        br_valid;
    logic [31:0] br_target;
    logic [15:0] n_results, n_taken;

    alu_result_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_out(in_out), .in_zf(in_zf), .in_aluop(in_aluop),
        .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_branch(in_branch), .in_bne(in_bne),
        .in_pc4(in_pc4), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zf(out_zf), .out_aluop(out_aluop),
        .out_rd(out_rd), .out_regwrite(out_regwrite),
        .br_valid(br_valid), .br_target(br_target),
        .n_results(n_results), .n_taken(n_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
    } ent_t;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        bne;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        exp_br;
        logic [31:0] exp_tgt;
    } vec_t;

    int          n_tests = 0;
    int          n_fail = 0;
    ent_t        q[$];
    logic [31:0] got[$];
    logic [31:0] sent[$];
    logic [15:0] exp_nres = '0;
    logic [15:0] exp_ntaken = '0;
    bit          last_acc;
    bit          exp_br;
    logic [31:0] exp_tgt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the stage is a FIFO of depth 2; redirect is decided from the
    // accepted instruction alone.
    task automatic cycle();
        bit   acc, dlv;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        dlv = out_ready && (q.size() > 0);
        if (out_valid && out_ready) got.push_back(out_result);
        e = '{in_out, in_zf, in_aluop, in_rd, in_regwrite};
        exp_br = acc && in_branch && (in_bne ? !in_zf : in_zf);
        exp_tgt = in_pc4 + in_imm * 4;
        @(posedge clk);
        if (dlv) begin
            void'(q.pop_front());
            exp_nres = exp_nres + 16'd1;
        end
        if (acc) q.push_back(e);
        if (exp_br) exp_ntaken = exp_ntaken + 16'd1;
        last_acc = acc;
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_zf", out_zf, q[0].zf);
            chk("out_aluop", out_aluop, q[0].op);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_regwrite", out_regwrite, q[0].rw);
        end
        chk("in_ready", in_ready, q.size() < 2);
        chk("br_valid", br_valid, exp_br);
        if (exp_br) chk("br_target", br_target, exp_tgt);
        chk("n_results", n_results, exp_nres);
        chk("n_taken", n_taken, exp_ntaken);
    endtask

    task automatic drive(input logic [31:0] res, input logic zf, input logic [3:0] op,
                         input logic [4:0] rd, input logic rw, input logic br,
                         input logic bne, input logic [31:0] pc4, input logic [31:0] imm);
        in_out = res; in_zf = zf; in_aluop = op; in_rd = rd; in_regwrite = rw;
        in_branch = br; in_bne = bne; in_pc4 = pc4; in_imm = imm;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [3:0] lops[4];
        int idx, cyc;
        logic [15:0] base;

        vecs[0] = '{32'd1, 1'b0, 4'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{32'd0, 1'b1, 4'd2, 5'd0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFFC, 1'b1, 32'hF0};
        vecs[2] = '{32'd0, 1'b1, 4'd2, 5'd0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h8, 1'b0, 32'h0};
        vecs[3] = '{32'd5, 1'b0, 4'd2, 5'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1, 1'b1, 32'h0};
        vecs[4] = '{32'hFFFF_0000, 1'b0, 4'd4, 5'd7, 1'b1, 1'b0, 1'b0, 32'h40, 32'h10, 1'b0, 32'h0};
        vecs[5] = '{32'd7, 1'b0, 4'd2, 5'd0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h4, 1'b0, 32'h0};
        lops = '{4'd4, 4'd5, 4'd6, 4'd7};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_br_valid", br_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_br_target", br_target, 0);
        chk("rst_n_results", n_results, 0);
        rst = 1'b0;

        // Single instructions through an empty stage.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].res, vecs[i].zf, vecs[i].op, vecs[i].rd, vecs[i].rw,
                  vecs[i].br, vecs[i].bne, vecs[i].pc4, vecs[i].imm);
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("vec%0d_br_valid", i), br_valid, vecs[i].exp_br);
            if (vecs[i].exp_br) chk($sformatf("vec%0d_br_target", i), br_target, vecs[i].exp_tgt);
            cycle();
            chk($sformatf("vec%0d_pulse_end", i), br_valid, 0);
        end
        chk("table_n_taken", n_taken, 2);
        chk("table_n_results", n_results, 6);

        // Backpressure: third push held off until space frees.
        got.delete();
        out_ready = 1'b0;
        drive(25, 0, 0, 1, 1, 0, 0, 0, 0); in_valid = 1'b1; cycle();
        drive(13, 0, 0, 2, 1, 0, 0, 0, 0); cycle();
        chk("bp_in_ready_low", in_ready, 0);
        drive(24, 0, 0, 3, 1, 0, 0, 0, 0); cycle();
        chk("bp_held_off", last_acc, 0);
        chk("bp_head", out_result, 25);
        out_ready = 1'b1;
        cyc = 0;
        while (!last_acc && cyc < 10) begin cycle(); cyc++; end
        in_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin cycle(); cyc++; end
        cycle();
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_order0", got[0], 25);
            chk("bp_order1", got[1], 13);
            chk("bp_order2", got[2], 24);
        end

        // Reset while FULL and stalled.
        out_ready = 1'b0;
        drive(50, 0, 0, 1, 1, 0, 0, 0, 0); in_valid = 1'b1; cycle();
        drive(51, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
        in_valid = 1'b0;
        chk("mr_full", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_n_results", n_results, 0);
        chk("mr_n_taken", n_taken, 0);
        chk("mr_out_result", out_result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); got.delete();
        exp_nres = '0; exp_ntaken = '0;
        out_ready = 1'b1;
        drive(77, 0, 0, 9, 1, 0, 0, 0, 0); in_valid = 1'b1; cycle();
        in_valid = 1'b0; cycle();
        chk("mr_first_count", got.size(), 1);
        if (got.size() > 0) chk("mr_first_value", got[0], 77);

        // Random streaming of logic ops against toggling backpressure.
        got.delete(); sent.delete();
        base = exp_nres;
        idx = 0; cyc = 0;
        drive($urandom, 0, lops[0], 0, 1, 0, 0, 0, 0);
        in_out = $urandom; in_zf = (in_out == 0); in_aluop = lops[$urandom_range(0, 3)];
        in_rd = 5'($urandom);
        while (idx < 20 && cyc < 400) begin
            in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            cyc++;
            if (last_acc) begin
                sent.push_back(in_out);
                idx++;
                in_out = $urandom; in_zf = (in_out == 0);
                in_aluop = lops[$urandom_range(0, 3)];
                in_rd = 5'($urandom);
            end
        end
        chk("stream_accept_budget", idx, 20);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin cycle(); cyc++; end
        cycle();
        chk("stream_count", got.size(), 20);
        if (got.size() == sent.size()) begin
            foreach (sent[i]) chk($sformatf("stream_item%0d", i), got[i], sent[i]);
        end
        chk("stream_n_results", n_results, base + 16'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

EX-side result register for the MIPS-32 datapath. It consumes the ALU's result word and zero flag together with the instruction's writeback and branch controls, and buffers them in a two-entry skid buffer behind a valid/ready handshake. It resolves beq/bne in the acceptance cycle and emits a one-cycle redirect pulse with the computed target. It sits between the ALU and the MEM/WB stage and is the consumer side of the ALU's (a, b, AluOp) → (zf, out) interface.

## Interface
- DATA_W, 32, datapath width of the ALU result, PC and immediate.
- REG_W, 5, destination register index width.
- CNT_W, 16, width of the status counters.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid ALU result.
- in_ready  out  1  stage can accept; registered.
- in_out  in  DATA_W  ALU result.
- in_zf  in  1  ALU zero flag.
- in_aluop  in  4  AluOp: 0 add, 2 sub, 4 and, 5 or, 6 xor, 7 nor, 10 slt.
- in_rd  in  REG_W  destination register.
- in_regwrite  in  1  writeback enable.
- in_branch  in  1  instruction is a conditional branch.
- in_bne  in  1  1 = bne, 0 = beq; ignored when in_branch = 0.
- in_pc4  in  DATA_W  PC + 4 of the instruction.
- in_imm  in  DATA_W  sign-extended branch offset, in words.
- out_valid  out  1  result available downstream.
- out_ready  in  1  downstream accepts.
- out_result, out_zf, out_aluop, out_rd, out_regwrite  out  as the matching inputs  buffered copies.
- br_valid  out  1  one-cycle redirect pulse.
- br_target  out  DATA_W  redirect address; valid only while br_valid = 1.
- n_results  out  CNT_W  count of results delivered downstream.
- n_taken  out  CNT_W  count of taken branches.

## Operation
- Accept occurs when in_valid & in_ready. Deliver occurs when out_valid & out_ready.
- Storage is a main register M, which drives the out_* ports, plus a skid register S. Occupancy is 0, 1 or 2.
- Occupancy states and transitions:
  - EMPTY: accept → ONE (entry goes to M).
  - ONE: accept with no deliver → FULL (entry goes to S). Deliver with no accept → EMPTY. Accept and deliver together → ONE (the new entry goes to M).
  - FULL: deliver → ONE (S moves to M). Accept is impossible because in_ready = 0.
- in_ready is 0 exactly when occupancy is FULL.
- Branch resolution happens on accept, independent of the downstream state:
  - taken = in_branch & (in_bne ? ~in_zf : in_zf).
  - br_target = in_pc4 + (in_imm << 2), truncated to DATA_W; wrap-around is silent.
- Non-branch instructions never raise br_valid. Branch entries still flow downstream, normally with in_regwrite = 0.
- Entry data is never modified; out_zf and out_aluop are passed through unchanged.
- n_results increments on each deliver. n_taken increments on each taken accept. Both wrap modulo 2^CNT_W.
- Reset (any time, including mid-transfer):
  - Occupancy → EMPTY; all buffered entries are discarded.
  - out_valid = 0, br_valid = 0, in_ready = 1.
  - out_* data = 0, br_target = 0, counters = 0.
  - No pulse or deliver completes in the cycle reset is asserted.

## Timing
- Latency from accept to out_valid is 1 cycle when EMPTY, or when ONE with a simultaneous deliver.
- br_valid is asserted in the cycle after a taken accept, for exactly 1 cycle, with br_target stable in that cycle.
- in_ready falls the cycle after the accept that fills S. It rises the cycle after the deliver from FULL.
- Throughput is one result per cycle while out_ready = 1.
- out_* holds stable while out_valid & ~out_ready.
- No combinational path from any input to any output.

## Test plan
- Reset then add: in_out = 1, in_zf = 0, in_rd = 3, in_regwrite = 1, out_ready = 1 → one cycle later out_valid = 1, out_result = 1, out_rd = 3; n_results = 1 after the deliver; br_valid stays 0.
- Backpressure: out_ready = 0, push results 25, 13, 24 back-to-back → in_ready = 0 after the second accept and the third input is held off. Then out_ready = 1 → delivered in the order 25, 13, 24, with none lost or duplicated.
- beq taken: sub result 0, in_zf = 1, in_branch = 1, in_bne = 0, in_pc4 = 0x100, in_imm = 0xFFFFFFFC → br_valid pulse with br_target = 0xF0; n_taken = 1.
- bne not taken: in_zf = 1, in_bne = 1 → br_valid stays 0 and the entry is still delivered. Then bne with in_zf = 0, in_pc4 = 0xFFFFFFFC, in_imm = 1 → br_target = 0x00000000 (wrap-around).
- Mid-operation reset: with FULL and out_ready = 0, assert rst for 1 cycle → out_valid = 0, in_ready = 1, counters = 0; the next accepted value is the first one delivered.
- Streaming: 20 consecutive logic ops with randomly toggled out_ready → output sequence equals the input sequence; n_results = 20.
